data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words of storage.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving the wait states between request accept and response (0..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr, input, 32 bits: the byte address.
REQ-009 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 The block SHALL have port req_funct3, input, 3 bits: RV32I load/store width code.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: a response is presented.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: the initiator accepts the response.
REQ-013 The block SHALL have port rsp_rdata, output, 32 bits: the extended load data, or 0 for stores and errors.
REQ-014 The block SHALL have port rsp_err, output, 1 bit: the access was illegal and had no side effect.

Function
REQ-015 The FSM SHALL have exactly three states, IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE, and rsp_valid SHALL be 1 only in RESP.
REQ-016 In IDLE, req_valid=1 SHALL accept the request, capture we/addr/wdata/funct3 into registers, and go to WAIT, or go directly to RESP when WAIT_CYCLES=0.
REQ-017 In WAIT, a down-counter loaded with WAIT_CYCLES SHALL decrement each cycle, and the FSM SHALL go to RESP on the edge where the counter reaches 0.
REQ-018 Latency SHALL be fixed: for a request accepted at edge N, rsp_valid SHALL rise after edge N+WAIT_CYCLES+1, regardless of access type.
REQ-019 Memory read/write SHALL commit on the edge entering RESP, and the response registers SHALL be loaded on that same edge.
REQ-020 In RESP, rsp_rdata and rsp_err SHALL be held stable until rsp_ready=1; the handshake edge SHALL return the FSM to IDLE, and no new request SHALL be accepted on that edge.
REQ-021 Loads SHALL return: funct3 0 (LB) byte addr[1:0] sign-extended; 1 (LH) halfword addr[1] sign-extended; 2 (LW) full word; 4 (LBU) byte zero-extended; 5 (LHU) halfword zero-extended.
REQ-022 Stores SHALL update: funct3 0 (SB) byte lane addr[1:0] only; 1 (SH) lanes selected by addr[1] only; 2 (SW) all four lanes; untouched lanes SHALL keep their prior contents.
REQ-023 The word index SHALL be addr[31:2] modulo DEPTH_WORDS, so out-of-range addresses wrap silently.
REQ-024 Illegal funct3 (load 3/6/7, store 3..7) SHALL give rsp_err=1, rsp_rdata=0, and no write.
REQ-025 A request accepted while a response is pending is impossible by construction, because req_ready=0 outside IDLE.

Reset
REQ-026 While rst=1, the state SHALL be IDLE, the counter 0, and the outputs req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-027 Reset asserted in WAIT SHALL abort the access with no write; reset asserted in RESP SHALL discard the response, the write having already committed.
REQ-028 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-029 With macro DATA_MEM_MISALIGN_TRAP_EN defined, a halfword with addr[0]=1 or a word with addr[1:0]!=0 SHALL give rsp_err=1, rsp_rdata=0, and no write.
REQ-030 Without DATA_MEM_MISALIGN_TRAP_EN, misaligned offset bits SHALL be ignored (halfword forced to lane addr[1], word to lane 0), and rsp_err SHALL be driven 0 for misalignment.

Structure
REQ-031 Package mem_pkg SHALL hold the funct3 load/store encodings as constants, the FSM state enum, and the helper function for byte-lane enable generation.
REQ-032 Sub-module mem_byte_array SHALL hold the storage: DEPTH_WORDS x 4 byte lanes, synchronous write with a 4-bit lane enable, and read data presented to the FSM.

Verification
REQ-033 SW 0xDEADBEEF at 0x100, then LW 0x100 -> rsp_rdata=0xDEADBEEF, rsp_valid asserted exactly WAIT_CYCLES+1 cycles after accept.
REQ-034 After REQ-033, SB 0x7F at 0x101, then LB 0x101 and LBU 0x103 -> 0x0000007F and 0x000000DE; LW 0x100 -> 0xDEAD7FEF.
REQ-035 LH 0x102 after REQ-034 -> 0xFFFFDEAD; LHU 0x102 -> 0x0000DEAD.
REQ-036 LW 0x101 -> with DATA_MEM_MISALIGN_TRAP_EN, rsp_err=1 and rdata=0; without it, rdata=0xDEAD7FEF and err=0. Store funct3=3 -> err=1 and memory unchanged.
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable and req_ready=0; assert rst in WAIT of an SW -> outputs at reset values and the target word unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the data memory responder: RV32I load/store width codes,
// FSM states, and access-decode helpers (lane enables, legality, alignment).
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Halfwords pick their lane pair from off[1] only; off[0] is ignored here.
   function automatic logic [3:0] lane_en(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] en;
      en = 4'b0000;
      case (f3)
         F3_B:    en = 4'b0001 << off;
         F3_H:    en = off[1] ? 4'b1100 : 4'b0011;
         F3_W:    en = 4'b1111;
         default: en = 4'b0000;
      endcase
      return en;
   endfunction

   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      logic bad;
      if (we)
         bad = (f3 > F3_W);
      else
         bad = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU));
      return bad;
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      return ((f3[1:0] == 2'd1) && off[0]) || ((f3[1:0] == 2'd2) && (off != 2'd0));
   endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Word-organised byte-lane storage: synchronous per-lane write, combinational read
// of the same word index. Contents are deliberately not reset.
module mem_byte_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic          clk,
   input  logic [AW-1:0] idx,
   input  logic [3:0]    wmask,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [3:0][7:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      for (int l = 0; l < 4; l++) begin
         if (wmask[l]) mem[idx][l] <= wdata[8*l +: 8];
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Data memory behind a valid/ready request/response pair with fixed wait states.
// Define DATA_MEM_MISALIGN_TRAP_EN to turn misaligned halfword/word accesses into errors.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   state_t        state, state_nxt;
   logic [3:0]    cnt;
   logic          cap_we;
   logic [31:0]   cap_addr, cap_wdata;
   logic [2:0]    cap_f3;

   logic          acc_we;
   logic [31:0]   acc_addr, acc_wdata;
   logic [2:0]    acc_f3;
   logic          enter_resp, acc_err;
   logic [29:0]   word_sel;
   logic [AW-1:0] word_idx;
   logic [3:0]    wmask;
   logic [31:0]   wlanes, mem_rdata, ld_data;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [31:0]   rdata_q;
   logic          err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (req_valid) state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
         S_WAIT:  if (cnt == 4'd0) state_nxt = S_RESP;
         S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == S_IDLE);
      rsp_valid = (state == S_RESP);
      rsp_rdata = rdata_q;
      rsp_err   = err_q;
   end

   assign enter_resp = (state_nxt == S_RESP) && (state != S_RESP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= 4'd0;
         cap_we    <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_f3    <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         if (state == S_IDLE && req_valid) begin
            cnt       <= 4'(WAIT_CYCLES);
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_f3    <= req_funct3;
         end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (enter_resp) begin
            rdata_q <= ld_data;
            err_q   <= acc_err;
         end
      end
   end

   // With zero wait states the access commits on the accept edge, before capture.
   always_comb begin
      if (state == S_IDLE) begin
         acc_we    = req_we;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_f3    = req_funct3;
      end else begin
         acc_we    = cap_we;
         acc_addr  = cap_addr;
         acc_wdata = cap_wdata;
         acc_f3    = cap_f3;
      end
   end

   assign word_sel = acc_addr[31:2];
   assign word_idx = AW'(word_sel % 30'(DEPTH_WORDS));

   always_comb begin
      acc_err = f3_illegal(acc_we, acc_f3);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
      acc_err = acc_err | misaligned(acc_f3, acc_addr[1:0]);
`endif
      wmask = (acc_we && !acc_err && enter_resp) ? lane_en(acc_f3, acc_addr[1:0]) : 4'b0000;

      wlanes = acc_wdata;
      case (acc_f3)
         F3_B:    wlanes = {4{acc_wdata[7:0]}};
         F3_H:    wlanes = {2{acc_wdata[15:0]}};
         default: wlanes = acc_wdata;
      endcase

      ld_byte = mem_rdata[{acc_addr[1:0], 3'b000} +: 8];
      ld_half = acc_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      ld_data = '0;
      if (!acc_we && !acc_err) begin
         case (acc_f3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_W:    ld_data = mem_rdata;
            F3_BU:   ld_data = {24'd0, ld_byte};
            F3_HU:   ld_data = {16'd0, ld_half};
            default: ld_data = '0;
         endcase
      end
   end

   mem_byte_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk   (clk),
      .idx   (word_idx),
      .wmask (wmask),
      .wdata (wlanes),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed and randomized load/store traffic against a byte-addressed reference model.
module tb_data_mem_responder;

   localparam int DEPTH = 1024;
   localparam int W     = 2;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [2:0]  req_funct3 = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int tests = 0;
   int fails = 0;

   // key = (word index mod DEPTH) * 4 + byte lane
   byte unsigned ref_mem [int unsigned];

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "/req_ready"}, 32'(req_ready), 32'd1);
      check({tag, "/rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "/rsp_rdata"}, rsp_rdata, 32'd0);
      check({tag, "/rsp_err"},   32'(rsp_err), 32'd0);
   endtask

   // Behavioural model: applies a store to ref_mem (when commit) and predicts the response.
   task automatic model(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input bit commit,
                        output logic [31:0] rd, output logic err);
      int unsigned wbase, off, size, start;
      bit legal, sgn;
      logic [31:0] val;
      wbase = ((addr >> 2) % DEPTH) * 4;
      off   = addr & 32'd3;
      size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      sgn   = (f3 < 3'd4);
      legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 < 3'd6);
      rd  = 32'd0;
      err = 1'b0;
      if (!legal || (TRAP && (off % size) != 0)) begin
         err = 1'b1;
         return;
      end
      start = off - (off % size);
      if (we) begin
         if (commit)
            for (int i = 0; i < int'(size); i++)
               ref_mem[wbase + start + i] = 8'(wdata >> (8 * i));
      end else begin
         val = 32'd0;
         for (int i = 0; i < int'(size); i++)
            val = val | (32'(ref_mem[wbase + start + i]) << (8 * i));
         if (sgn && size < 4 && val[8*size-1])
            val = val | (32'hFFFF_FFFF << (8 * size));
         rd = val;
      end
   endtask

   task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input string tag);
      @(negedge clk);
      check({tag, "/req_ready"}, 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_addr   = addr;
      req_wdata  = wdata;
      req_funct3 = f3;
      @(posedge clk);
      #1;
      // scramble the request bus so only captured values can matter
      req_valid  = 1'b0;
      req_we     = 1'($urandom_range(0, 1));
      req_addr   = $urandom;
      req_wdata  = $urandom;
      req_funct3 = 3'($urandom_range(0, 7));
   endtask

   task automatic wait_rsp(input string tag);
      int lat;
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "/latency"}, 32'(lat), 32'(W + 1));
   endtask

   task automatic xact(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input int hold, input string tag);
      logic [31:0] exp_rd, held;
      logic exp_err;
      model(we, addr, wdata, f3, 1'b1, exp_rd, exp_err);
      issue(we, addr, wdata, f3, tag);
      wait_rsp(tag);
      held = rsp_rdata;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         check($sformatf("%s/hold%0d_valid", tag, h), 32'(rsp_valid), 32'd1);
         check($sformatf("%s/hold%0d_ready", tag, h), 32'(req_ready), 32'd0);
         check($sformatf("%s/hold%0d_rdata", tag, h), rsp_rdata, held);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      check({tag, "/rdata"}, rsp_rdata, exp_rd);
      check({tag, "/err"},   32'(rsp_err), 32'(exp_err));
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check({tag, "/idle_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "/idle_ready"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] d_rd;
      logic d_err;

      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      xact(1'b1, 32'h100, 32'hDEADBEEF, 3'd2, 0, "sw_100");
      xact(1'b0, 32'h100, 32'h0,        3'd2, 0, "lw_100");
      xact(1'b1, 32'h101, 32'h0000007F, 3'd0, 0, "sb_101");
      xact(1'b0, 32'h101, 32'h0,        3'd0, 0, "lb_101");
      xact(1'b0, 32'h103, 32'h0,        3'd4, 0, "lbu_103");
      xact(1'b0, 32'h100, 32'h0,        3'd2, 0, "lw_100_b");
      xact(1'b0, 32'h102, 32'h0,        3'd1, 0, "lh_102");
      xact(1'b0, 32'h102, 32'h0,        3'd5, 0, "lhu_102");
      xact(1'b0, 32'h101, 32'h0,        3'd2, 0, "lw_101_mis");
      xact(1'b1, 32'h100, 32'h01234567, 3'd3, 0, "st_f3_3");
      xact(1'b0, 32'h100, 32'h0,        3'd2, 5, "lw_100_hold");

      // reset while an SW is waiting: no write may land
      issue(1'b1, 32'h100, 32'h12345678, 3'd2, "rst_wait");
      rst = 1'b1;
      #3;
      check_reset_outputs("rst_wait_async");
      @(posedge clk);
      #1;
      check_reset_outputs("rst_wait_held");
      @(negedge clk);
      rst = 1'b0;
      xact(1'b0, 32'h100, 32'h0, 3'd2, 0, "lw_after_rst_wait");

      // reset while a store response is pending: write already committed
      model(1'b1, 32'h104, 32'h55AA55AA, 3'd2, 1'b1, d_rd, d_err);
      issue(1'b1, 32'h104, 32'h55AA55AA, 3'd2, "rst_resp");
      wait_rsp("rst_resp");
      rst = 1'b1;
      #3;
      check_reset_outputs("rst_resp_async");
      @(negedge clk);
      rst = 1'b0;
      xact(1'b0, 32'h104, 32'h0, 3'd2, 0, "lw_after_rst_resp");

      // wrapped alias of 0x100 must hit the same word
      xact(1'b0, 32'h100 + 32'(DEPTH * 4), 32'h0, 3'd2, 0, "lw_wrap");

      for (int w = 0; w < 16; w++)
         xact(1'b1, 32'(w * 4), $urandom, 3'd2, 0, $sformatf("init_w%0d", w));

      for (int n = 0; n < 150; n++) begin
         int unsigned wi, k, off;
         logic [31:0] a;
         bit we;
         logic [2:0] f3;
         wi  = $urandom_range(0, 15);
         k   = $urandom_range(0, 3);
         off = $urandom_range(0, 3);
         we  = 1'($urandom_range(0, 1));
         f3  = 3'($urandom_range(0, 7));
         a   = 32'((wi + k * DEPTH) * 4 + off);
         xact(we, a, $urandom, f3, 0, $sformatf("rnd%0d_%s_f%0d_%h", n, we ? "st" : "ld", f3, a));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
